// File: rtl/addsub_pkg.sv
// Shared types and encodings for the add/subtract issue stage.
// Imported by the issue controller and the adder core.
package addsub_pkg;

    localparam int WIDTH = 4;

    localparam logic SEL_ADD = 1'b0;
    localparam logic SEL_SUB = 1'b1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sel;
    } entry_t;

endpackage

// File: rtl/adder_subtractor.sv
// Combinational add/subtract core.
// Subtract is a + ~b + 1, so cout = 1 means no borrow.
module adder_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sout,
    output logic             cout
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   r;

    assign bx = sel ? ~b : b;
    assign r  = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sel};

    assign sout = r[WIDTH-1:0];
    assign cout = r[WIDTH];

endmodule

// File: rtl/addsub_issue_ctrl.sv
// Operand FIFO feeding adder_subtractor with a registered,
// back-pressured result handshake.
module addsub_issue_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = addsub_pkg::WIDTH,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_a,
    input  logic [WIDTH-1:0]         in_b,
    input  logic                     in_sel,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_sout,
    output logic                     out_cout,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH) + 1;
    localparam int AW = PW - 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    entry_t        mem [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          ptr_eq;
    logic          msb_diff;
    logic [1:0]    state;
    logic          push;
    logic          issue;
    logic [WIDTH-1:0] sum;
    logic          carry;

    assign ptr_eq   = wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign msb_diff = wr_ptr[AW] != rd_ptr[AW];
    assign level    = wr_ptr - rd_ptr;

    // Occupancy class decoded purely from the pointers.
    always_comb begin
        state = ST_PARTIAL;
        unique case (1'b1)
            ptr_eq && !msb_diff: state = ST_EMPTY;
            ptr_eq && msb_diff:  state = ST_FULL;
            default:             state = ST_PARTIAL;
        endcase
    end

    assign in_ready = state != ST_FULL;
    assign push     = in_valid && in_ready;
    assign issue    = (state != ST_EMPTY) && (!out_valid || out_ready);
    assign head     = mem[rd_ptr[AW-1:0]];

    adder_subtractor #(.WIDTH(WIDTH)) u_core (
        .a    (head.a),
        .b    (head.b),
        .sel  (head.sel),
        .sout (sum),
        .cout (carry)
    );

    // Operand storage; contents are don't-care until pushed.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr[AW-1:0]] <= '{a: in_a, b: in_b, sel: in_sel};
        end
    end

    // Pointer advance and result register; flush wins over everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
            out_sout  <= '0;
            out_cout  <= 1'b0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (issue) begin
                rd_ptr    <= rd_ptr + PW'(1);
                out_valid <= 1'b1;
                out_sout  <= sum;
                out_cout  <= carry;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_addsub_issue_ctrl.sv
// Directed bench for addsub_issue_ctrl (WIDTH 4, DEPTH 4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_addsub_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       in_sel;
    logic       flush;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_sout;
    logic       out_cout;
    logic [2:0] level;

    int checks = 0;
    int errors = 0;

    addsub_issue_ctrl #(.WIDTH(4), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_sel    (in_sel),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sout  (out_sout),
        .out_cout  (out_cout),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, out_sout, out_cout, level} !== {1'b1, 1'b0, 4'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset: rdy=%b ov=%b s=%h c=%b lvl=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, out_sout, out_cout, level);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_arith;
        logic [3:0] ta [3];
        logic [3:0] tb [3];
        logic       ts [3];
        logic [3:0] es [3];
        logic       ec [3];
        ta = '{4'hF, 4'hB, 4'hA};
        tb = '{4'hF, 4'hC, 4'h5};
        ts = '{1'b0, 1'b1, 1'b1};
        es = '{4'hE, 4'hF, 4'h5};
        ec = '{1'b1, 1'b0, 1'b1};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = ta[i]; in_b = tb[i]; in_sel = ts[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0 || level !== 3'd1) begin
                errors++;
                $display("FAIL arith_lat%0d: ov=%b lvl=%0d, required ov=0 lvl=1",
                         i, out_valid, level);
            end
            tick();
            checks++;
            if ({out_valid, out_sout, out_cout} !== {1'b1, es[i], ec[i]}) begin
                errors++;
                $display("FAIL arith%0d: ov=%b s=%h c=%b, required 1 %h %b",
                         i, out_valid, out_sout, out_cout, es[i], ec[i]);
            end
            tick();
            checks++;
            if ({out_valid, out_sout, out_cout, level} !== {1'b0, es[i], ec[i], 3'd0}) begin
                errors++;
                $display("FAIL drain_hold%0d: ov=%b s=%h c=%b lvl=%0d, required 0 %h %b 0",
                         i, out_valid, out_sout, out_cout, level, es[i], ec[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 4'(i + 1); in_b = 4'(i); in_sel = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if ({in_ready, level, out_valid, out_sout} !== {1'b0, 3'd4, 1'b1, 4'd1}) begin
            errors++;
            $display("FAIL full: rdy=%b lvl=%0d ov=%b s=%h, required 0 4 1 1",
                     in_ready, level, out_valid, out_sout);
        end
        tick();
        checks++;
        if (out_sout !== 4'd1 || level !== 3'd4) begin
            errors++;
            $display("FAIL stall_hold: s=%h lvl=%0d, required 1 4", out_sout, level);
        end
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({out_valid, out_sout, level} !== {1'b1, 4'(2 * k + 1), 3'(4 - k)}) begin
                errors++;
                $display("FAIL drain_order%0d: ov=%b s=%h lvl=%0d, required 1 %h %0d",
                         k, out_valid, out_sout, level, 4'(2 * k + 1), 4 - k);
            end
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drained: ov=%b lvl=%0d rdy=%b, required 0 0 1",
                     out_valid, level, in_ready);
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] a;
        logic       s;
        logic [3:0] es;
        logic       ec;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            in_valid = (c < 12);
            in_a = 4'(c + 5); in_b = 4'd3; in_sel = c[0];
            tick();
            if (c < 12) begin
                checks++;
                if (level !== 3'd1) begin
                    errors++;
                    $display("FAIL b2b_level%0d: lvl=%0d, required 1", c, level);
                end
            end
            if (c >= 1 && c <= 12) begin
                a = 4'(c - 1 + 5);
                s = c[0] ^ 1'b1;
                es = s ? 4'(a - 4'd3) : 4'(a + 4'd3);
                ec = s ? (a >= 4'd3) : ((a + 5'd3) > 5'd15);
                checks++;
                if ({out_valid, out_sout, out_cout} !== {1'b1, es, ec}) begin
                    errors++;
                    $display("FAIL b2b%0d: ov=%b s=%h c=%b, required 1 %h %b",
                             c, out_valid, out_sout, out_cout, es, ec);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || level !== 3'd0) begin
            errors++;
            $display("FAIL b2b_end: ov=%b lvl=%0d, required 0 0", out_valid, level);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 4'd1; in_b = 4'd1; in_sel = 1'b0;
            tick();
        end
        checks++;
        if (level !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_flush: lvl=%0d ov=%b, required 3 1", level, out_valid);
        end
        flush = 1'b1; in_a = 4'd9; in_b = 4'd9;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if ({level, out_valid, in_ready} !== {3'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL flush: lvl=%0d ov=%b rdy=%b, required 0 0 1",
                     level, out_valid, in_ready);
        end
        out_ready = 1'b1;
        tick();
        tick();
        checks++;
        if (level !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: lvl=%0d ov=%b, required 0 0", level, out_valid);
        end
        in_valid = 1'b1; in_a = 4'd7; in_b = 4'd2; in_sel = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_sout, out_cout} !== {1'b1, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL post_flush: ov=%b s=%h c=%b, required 1 5 1",
                     out_valid, out_sout, out_cout);
        end
        tick();
    endtask

    task automatic test_async_reset;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 4'd6; in_b = 4'd6; in_sel = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (level !== 3'd4 || out_sout !== 4'hC) begin
            errors++;
            $display("FAIL pre_reset: lvl=%0d s=%h, required 4 c", level, out_sout);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_sout, out_cout, level} !== {1'b1, 1'b0, 4'h0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: rdy=%b ov=%b s=%h c=%b lvl=%0d, required 1 0 0 0 0",
                     in_ready, out_valid, out_sout, out_cout, level);
        end
        #3;
        rst_n = 1'b1;
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = 4'd3; in_b = 4'd9; in_sel = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        checks++;
        if ({out_valid, out_sout, out_cout} !== {1'b1, 4'hC, 1'b0}) begin
            errors++;
            $display("FAIL post_reset: ov=%b s=%h c=%b, required 1 c 0",
                     out_valid, out_sout, out_cout);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
